axi_txn_sched: RTL
==================

AXI_TXN_SCHED -- requirements
Module: axi_txn_sched

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 64, data width.
REQ-003 Parameter TIMEOUT_CYC, default 255, watchdog limit in cycles (8-bit counter).
REQ-004 ACLK  input  1  single clock, all state on rising edge.
REQ-005 ARESETn  input  1  asynchronous active-low reset.
REQ-006 wr_req  input  1  write request (level); wr_addr  input  ADDR_W; wr_data  input  DATA_W.
REQ-007 rd_req  input  1  read request (level); rd_addr  input  ADDR_W.
REQ-008 wr_ack, rd_ack  output  1 each  one-cycle pulse when request captured.
REQ-009 tx_en  output  5  channel enables {AW,W,B,AR,R} = bits [4:0].
REQ-010 mgr_tx_AW, mgr_tx_AR  output  ADDR_W; mgr_tx_W  output  DATA_W  captured payloads.
REQ-011 mgr_new_data  input  5  per-channel completion flags, same bit order as tx_en.
REQ-012 mgr_bresp, mgr_rresp  input  2; mgr_rx_R  input  DATA_W.
REQ-013 wr_done, rd_done  output  1 each  one-cycle completion pulses; resp  output  2; rd_data  output  DATA_W.
REQ-014 busy  output  1 (state != IDLE); timeout_err  output  1  one-cycle pulse.

Function
REQ-015 FSM states IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R.
REQ-016 In IDLE with a request: capture addr/data into mgr_tx_* registers, pulse the matching ack next cycle, enter WR_AW or RD_AR.
REQ-017 wr_req and rd_req both high in IDLE: round-robin; the type not served last wins; after reset write wins.
REQ-018 tx_en is a one-hot decode of the state register (WR_AW->bit4, WR_W->bit3, WR_B->bit2, RD_AR->bit1, RD_R->bit0); all-zero in IDLE; no combinational path from inputs.
REQ-019 In each channel state, mgr_new_data bit for that channel high -> advance next cycle: WR_AW->WR_W->WR_B->IDLE, RD_AR->RD_R->IDLE.
REQ-020 mgr_new_data bits for channels other than the current state are ignored.
REQ-021 Leaving WR_B: resp <= mgr_bresp, wr_done pulses one cycle; leaving RD_R: resp <= mgr_rresp, rd_data <= mgr_rx_R, rd_done pulses.
REQ-022 Minimum write latency: ack to wr_done = 3 cycles when every flag returns in the first cycle of its state; read = 2 cycles.
REQ-023 Requests arriving while busy are not captured; they are served when IDLE is re-entered, with no idle cycle required between transactions.
REQ-024 mgr_tx_* hold their value until the next capture.

Reset
REQ-025 ARESETn low asynchronously forces IDLE; tx_en, acks, dones, timeout_err, busy = 0; resp = 2'b00; rd_data, mgr_tx_* = 0; arbiter favours write.
REQ-026 Reset mid-transaction abandons it with no done pulse; release resumes in IDLE.

Configuration
REQ-027 Macro AXI_TXN_SCHED_TIMEOUT_EN defined: a counter clears on each state entry and increments in channel states; when it reaches TIMEOUT_CYC without the expected flag, the FSM returns to IDLE, timeout_err pulses, resp = 2'b10, and no done pulses.
REQ-028 Macro AXI_TXN_SCHED_TIMEOUT_EN undefined: no counter; wait indefinitely; timeout_err tied 0.

Structure
REQ-029 Package axi_sched_pkg holds the state enum, channel bit index constants (CH_AW=4, CH_W=3, CH_B=2, CH_AR=1, CH_R=0), and response codes OKAY=2'b00, SLVERR=2'b10.
REQ-030 Sub-module axi_sched_arb implements the 2-way round-robin grant with a last-served flag.

Verification
REQ-031 wr_req, addr 0x1000, data 0xDEAD_BEEF, flags returned immediately, bresp 00 -> tx_en sequence 10000, 01000, 00100; wr_done with resp 00.
REQ-032 rd_req, addr 0x2000, R flag with rx_R 0x55AA and rresp 00 after 4 cycles -> tx_en 00010 then 00001 held for 4 cycles; rd_done with rd_data 0x55AA.
REQ-033 wr_req and rd_req held high together -> grant order write, read, write; acks alternate.
REQ-034 Spurious mgr_new_data 00001 during WR_AW -> FSM stays in WR_AW.
REQ-035 ARESETn pulsed low during WR_W -> tx_en 0 immediately, no wr_done, IDLE after release.
REQ-036 With TIMEOUT_EN defined and the B flag withheld -> timeout_err after 255 cycles in WR_B, resp 10, busy 0 next cycle.

Source files
------------

// File: rtl/axi_sched_pkg.sv
// axi_sched_pkg: shared state encoding, channel bit positions and response
// codes for the AXI transaction scheduler.
package axi_sched_pkg;

    // Scheduler states; each channel state owns exactly one tx_en bit
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_AW = 3'd1,
        WR_W  = 3'd2,
        WR_B  = 3'd3,
        RD_AR = 3'd4,
        RD_R  = 3'd5
    } SchedState;

    localparam int CH_AW = 4;
    localparam int CH_W  = 3;
    localparam int CH_B  = 2;
    localparam int CH_AR = 1;
    localparam int CH_R  = 0;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_sched_arb.sv
// axi_sched_arb: two-way round-robin grant between write and read requests.
// A tie goes to whichever type was not captured last; after reset that is write.
module axi_sched_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic i_wrReq,
    input  logic i_rdReq,
    input  logic i_update,
    output logic o_grantWr,
    output logic o_grantRd
);

    logic r_lastWr;

    // Grant write unless read is also asking and write was served last
    always_comb begin
        o_grantWr = i_wrReq && (!i_rdReq || !r_lastWr);
        o_grantRd = i_rdReq && !o_grantWr;
    end

    // Remember the type of each capture; reset records "read" so write leads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastWr <= 1'b0;
        end else if (i_update) begin
            r_lastWr <= o_grantWr;
        end
    end

endmodule

// File: rtl/axi_txn_sched.sv
// axi_txn_sched: sequences one AXI write (AW, W, B) or read (AR, R) at a time.
// Optional watchdog: define AXI_TXN_SCHED_TIMEOUT_EN to abort a channel state
// that waits TIMEOUT_CYC cycles for its completion flag.
module axi_txn_sched
    import axi_sched_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              wr_ack,
    output logic              rd_ack,
    output logic [4:0]        tx_en,
    output logic [ADDR_W-1:0] mgr_tx_AW,
    output logic [ADDR_W-1:0] mgr_tx_AR,
    output logic [DATA_W-1:0] mgr_tx_W,
    input  logic [4:0]        mgr_new_data,
    input  logic [1:0]        mgr_bresp,
    input  logic [1:0]        mgr_rresp,
    input  logic [DATA_W-1:0] mgr_rx_R,
    output logic              wr_done,
    output logic              rd_done,
    output logic [1:0]        resp,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              timeout_err
);

    SchedState r_state;
    SchedState w_nextState;
    logic      w_grantWr;
    logic      w_grantRd;
    logic      w_capWr;
    logic      w_capRd;
    logic      w_wrDone;
    logic      w_rdDone;
    logic      w_timeoutHit;
    logic      w_timeout;

    axi_sched_arb u_arb (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .i_wrReq   (wr_req),
        .i_rdReq   (rd_req),
        .i_update  (w_capWr || w_capRd),
        .o_grantWr (w_grantWr),
        .o_grantRd (w_grantRd)
    );

`ifdef AXI_TXN_SCHED_TIMEOUT_EN
    logic [7:0] r_timer;

    // Count cycles spent in the current channel state; any state change restarts it
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_timer <= 8'd0;
        end else if (r_state == IDLE || r_state != w_nextState) begin
            r_timer <= 8'd0;
        end else begin
            r_timer <= r_timer + 8'd1;
        end
    end

    assign w_timeout = (r_state != IDLE) && (r_timer == 8'(TIMEOUT_CYC - 1));
`else
    // Watchdog compiled out: channel states wait for their flag indefinitely
    assign w_timeout = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state plus capture/completion strobes; only the current channel's flag matters
    always_comb begin
        w_nextState  = r_state;
        w_capWr      = 1'b0;
        w_capRd      = 1'b0;
        w_wrDone     = 1'b0;
        w_rdDone     = 1'b0;
        w_timeoutHit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grantWr) begin
                    w_nextState = WR_AW;
                    w_capWr     = 1'b1;
                end else if (w_grantRd) begin
                    w_nextState = RD_AR;
                    w_capRd     = 1'b1;
                end
            end
            WR_AW: begin
                if (mgr_new_data[CH_AW]) begin
                    w_nextState = WR_W;
                end else if (w_timeout) begin
                    w_nextState  = IDLE;
                    w_timeoutHit = 1'b1;
                end
            end
            WR_W: begin
                if (mgr_new_data[CH_W]) begin
                    w_nextState = WR_B;
                end else if (w_timeout) begin
                    w_nextState  = IDLE;
                    w_timeoutHit = 1'b1;
                end
            end
            WR_B: begin
                if (mgr_new_data[CH_B]) begin
                    w_nextState = IDLE;
                    w_wrDone    = 1'b1;
                end else if (w_timeout) begin
                    w_nextState  = IDLE;
                    w_timeoutHit = 1'b1;
                end
            end
            RD_AR: begin
                if (mgr_new_data[CH_AR]) begin
                    w_nextState = RD_R;
                end else if (w_timeout) begin
                    w_nextState  = IDLE;
                    w_timeoutHit = 1'b1;
                end
            end
            RD_R: begin
                if (mgr_new_data[CH_R]) begin
                    w_nextState = IDLE;
                    w_rdDone    = 1'b1;
                end else if (w_timeout) begin
                    w_nextState  = IDLE;
                    w_timeoutHit = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Channel enables decode the state register only, so no input reaches tx_en
    always_comb begin
        tx_en = 5'b00000;
        case (r_state)
            WR_AW:   tx_en[CH_AW] = 1'b1;
            WR_W:    tx_en[CH_W]  = 1'b1;
            WR_B:    tx_en[CH_B]  = 1'b1;
            RD_AR:   tx_en[CH_AR] = 1'b1;
            RD_R:    tx_en[CH_R]  = 1'b1;
            default: tx_en = 5'b00000;
        endcase
    end

    assign busy = (r_state != IDLE);

    // Registered handshakes, captured payloads and completion results
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ack      <= 1'b0;
            rd_ack      <= 1'b0;
            wr_done     <= 1'b0;
            rd_done     <= 1'b0;
            timeout_err <= 1'b0;
            resp        <= OKAY;
            rd_data     <= '0;
            mgr_tx_AW   <= '0;
            mgr_tx_AR   <= '0;
            mgr_tx_W    <= '0;
        end else begin
            wr_ack      <= w_capWr;
            rd_ack      <= w_capRd;
            wr_done     <= w_wrDone;
            rd_done     <= w_rdDone;
            timeout_err <= w_timeoutHit;
            if (w_capWr) begin
                mgr_tx_AW <= wr_addr;
                mgr_tx_W  <= wr_data;
            end
            if (w_capRd) begin
                mgr_tx_AR <= rd_addr;
            end
            if (w_wrDone) begin
                resp <= mgr_bresp;
            end else if (w_rdDone) begin
                resp    <= mgr_rresp;
                rd_data <= mgr_rx_R;
            end else if (w_timeoutHit) begin
                resp <= SLVERR;
            end
        end
    end

endmodule
